// File: rtl/seg_display_monitor.sv
// seg_display_monitor: receive-side decoder for a multiplexed 4-digit
// 7-segment bus. Filters glitches, decodes each accepted digit back to BCD,
// assembles MM:SS frames, counts decode errors and flags a stalled display.
module seg_display_monitor #(
  parameter int STABLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] anode_in,
  input  logic [6:0] seg_in,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [3:0] digit_blank,
  output logic       frame_valid,
  output logic       decode_err,
  output logic [7:0] err_count,
  output logic       stale
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] STABLE_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYCLES);

  // Segment pattern -> {legal, value}; blank and illegal both report legal=0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Anode select -> {valid, position}; position 3 = minutes tens .. 0 = seconds ones.
  function automatic logic [2:0] anode_decode(input logic [3:0] an);
    logic [2:0] r;
    case (an)
      4'b0111: r = {1'b1, 2'd3};
      4'b1011: r = {1'b1, 2'd2};
      4'b1101: r = {1'b1, 2'd1};
      4'b1110: r = {1'b1, 2'd0};
      default: r = {1'b0, 2'd0};
    endcase
    return r;
  endfunction

  // Registered state
  logic [10:0]      sync1_q, sync2_q;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       mask_q, mask_d;
  logic [5:0]       minutes_q, minutes_d;
  logic [5:0]       seconds_q, seconds_d;
  logic [3:0]       blank_q, blank_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             stale_q, stale_d;

  // Decode helpers
  logic       change_s;
  logic       accept_s;
  logic       take_s;
  logic       an_ok_s;
  logic [1:0] pos_s;
  logic       seg_ok_s;
  logic [3:0] seg_val_s;
  logic       seg_blank_s;
  logic       range_bad_s;

  // Next-state logic: glitch filter, digit decode, frame assembly, timeout.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    digit_d    = digit_q;
    pend_d     = pend_q;
    mask_d     = mask_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    blank_d    = blank_q;
    fv_d       = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    to_cnt_d   = to_cnt_q;
    stale_d    = stale_q;

    // The word entering sync2 this edge is compared against the one leaving it.
    change_s = (sync1_q != sync2_q);
    if (change_s) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
    // Fires only on the step into saturation, so once per stable period.
    accept_s = !change_s && (stab_cnt_q == STABLE_LAST);

    {an_ok_s, pos_s}        = anode_decode(sync2_q[10:7]);
    {seg_ok_s, seg_val_s}   = seg_decode(sync2_q[6:0]);
    seg_blank_s             = (sync2_q[6:0] == 7'b1111111);
    // Positions 3 and 1 hold tens digits, which cannot exceed 5.
    range_bad_s             = pos_s[0] && (seg_val_s > 4'd5);
    take_s                  = accept_s && an_ok_s;

    // Publish the frame from the mask/digits as they stood before this edge.
    if (mask_q == 4'b1111) begin
      fv_d      = 1'b1;
      minutes_d = 6'(digit_q[3]) * 6'd10 + 6'(digit_q[2]);
      seconds_d = 6'(digit_q[1]) * 6'd10 + 6'(digit_q[0]);
      blank_d   = pend_q;
      mask_d    = 4'b0000;
    end else begin
      fv_d      = 1'b0;
    end

    if (take_s) begin
      if (seg_blank_s) begin
        mask_d[pos_s] = 1'b1;
        pend_d[pos_s] = 1'b1;
      end else if (seg_ok_s && !range_bad_s) begin
        digit_d[pos_s] = seg_val_s;
        pend_d[pos_s]  = 1'b0;
        mask_d[pos_s]  = 1'b1;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
    end else begin
      err_d = 1'b0;
    end

    if (take_s) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
    stale_d = (to_cnt_d >= TO_MAX);
  end

  // State registers with synchronous active-low reset; synchronizers idle high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 11'h7FF;
      sync2_q    <= 11'h7FF;
      stab_cnt_q <= '0;
      digit_q    <= '0;
      pend_q     <= 4'b0000;
      mask_q     <= 4'b0000;
      minutes_q  <= 6'd0;
      seconds_q  <= 6'd0;
      blank_q    <= 4'b0000;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      to_cnt_q   <= '0;
      stale_q    <= 1'b0;
    end else begin
      sync1_q    <= {anode_in, seg_in};
      sync2_q    <= sync1_q;
      stab_cnt_q <= stab_cnt_d;
      digit_q    <= digit_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      blank_q    <= blank_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stale_q    <= stale_d;
    end
  end

  assign minutes     = minutes_q;
  assign seconds     = seconds_q;
  assign digit_blank = blank_q;
  assign frame_valid = fv_q;
  assign decode_err  = err_q;
  assign err_count   = err_cnt_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg_display_monitor.sv
// Self-checking bench for seg_display_monitor with a run-length reference model.
module tb_seg_display_monitor;
  localparam int S = 4;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] anode_in;
  logic [6:0] seg_in;
  logic [5:0] minutes, seconds;
  logic [3:0] digit_blank;
  logic       frame_valid, decode_err, stale;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  seg_display_monitor #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .anode_in(anode_in), .seg_in(seg_in),
    .minutes(minutes), .seconds(seconds), .digit_blank(digit_blank),
    .frame_valid(frame_valid), .decode_err(decode_err),
    .err_count(err_count), .stale(stale)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Reference model state
  int         m_dig [4];
  bit  [3:0]  m_pend, m_mask;
  int         m_min, m_sec, m_errcnt, m_idle, m_frames;
  logic [3:0] m_blank;
  bit         m_fv, m_err, m_stale;
  int         run;
  logic [10:0] last_w, acc_w;
  bit         acc_pend;

  // Observation bookkeeping
  int cyc = 0, div = 0, fv_n = 0, err_n = 0, fv_cyc = 0, rise_cyc = -1, fall_cyc = -1;
  bit stale_prev = 1'b0;

  function automatic int pos_of(input logic [3:0] an);
    case (an)
      4'b0111: return 3;
      4'b1011: return 2;
      4'b1101: return 1;
      4'b1110: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int val_of(input logic [6:0] sg);
    for (int i = 0; i < 10; i++) if (pat[i] == sg) return i;
    return -1;
  endfunction

  function automatic logic [6:0] dp(input int d);
    return pat[d];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_pend = 4'b0; m_mask = 4'b0; m_min = 0; m_sec = 0; m_errcnt = 0; m_idle = 0;
    m_blank = 4'b0; m_fv = 0; m_err = 0; m_stale = 0;
    last_w = 11'h7FF; run = S + 2; acc_pend = 0; acc_w = 11'h7FF;
  endtask

  // One clock edge of the spec-level model; w is the pin word sampled at this edge.
  task automatic model_edge(input logic [10:0] w);
    bit took;
    int p, v;
    took = 0; m_fv = 0; m_err = 0;
    if (m_mask == 4'b1111) begin
      m_fv = 1; m_frames++;
      m_min = m_dig[3] * 10 + m_dig[2];
      m_sec = m_dig[1] * 10 + m_dig[0];
      m_blank = m_pend;
      m_mask = 4'b0;
    end
    if (acc_pend) begin
      p = pos_of(acc_w[10:7]);
      if (p >= 0) begin
        took = 1;
        if (acc_w[6:0] == 7'b1111111) begin
          m_mask[p] = 1'b1; m_pend[p] = 1'b1;
        end else begin
          v = val_of(acc_w[6:0]);
          if (v >= 0 && !((p == 3 || p == 1) && v > 5)) begin
            m_dig[p] = v; m_pend[p] = 1'b0; m_mask[p] = 1'b1;
          end else begin
            m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
          end
        end
      end
    end
    if (took) m_idle = 0;
    else if (m_idle < T) m_idle++;
    m_stale = (m_idle >= T);
    // A pin word held S+1 samples is accepted on the following edge (2+S latency).
    if (w == last_w) begin
      if (run < S + 2) run++;
    end else begin
      run = 1; last_w = w;
    end
    acc_pend = (run == S + 1);
    acc_w = w;
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] sg);
    anode_in = an; seg_in = sg;
    @(posedge clk); #1;
    cyc++;
    model_edge({an, sg});
    if (frame_valid === 1'b1) begin fv_n++; fv_cyc = cyc; end
    if (decode_err === 1'b1) err_n++;
    if (stale === 1'b1 && !stale_prev) rise_cyc = cyc;
    if (stale === 1'b0 && stale_prev) fall_cyc = cyc;
    stale_prev = (stale === 1'b1);
    if (frame_valid !== m_fv || decode_err !== m_err || stale !== m_stale ||
        minutes !== 6'(m_min) || seconds !== 6'(m_sec) || digit_blank !== m_blank ||
        err_count !== 8'(m_errcnt)) div++;
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
    for (int i = 0; i < n; i++) step(an, sg);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      anode_in = 4'($urandom); seg_in = 7'($urandom);
      @(posedge clk); #1;
    end
    tests_run++; if (minutes !== 6'd0) begin tests_failed++; $display("FAIL reset_minutes got %0d want 0", minutes); end
    tests_run++; if (seconds !== 6'd0) begin tests_failed++; $display("FAIL reset_seconds got %0d want 0", seconds); end
    tests_run++; if (digit_blank !== 4'b0) begin tests_failed++; $display("FAIL reset_blank got %b want 0000", digit_blank); end
    tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
    tests_run++; if (decode_err !== 1'b0) begin tests_failed++; $display("FAIL reset_decode_err got %b want 0", decode_err); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL reset_stale got %b want 0", stale); end
    model_reset();
    rst = 1'b1;
    hold(4'hF, 7'h7F, 8);
  endtask

  task automatic test_normal_frame();
    int c0, d0;
    c0 = cyc; d0 = div; fv_n = 0;
    hold(4'b0111, dp(1), 10); hold(4'b1011, dp(2), 10);
    hold(4'b1101, dp(3), 10); hold(4'b1110, dp(4), 10);
    hold(4'hF, 7'h7F, 5);
    tests_run++; if (fv_n !== 1) begin tests_failed++; $display("FAIL normal_fv_count got %0d want 1", fv_n); end
    tests_run++; if (fv_cyc - c0 !== 30 + S + 2 + 1) begin tests_failed++; $display("FAIL normal_fv_cycle got %0d want %0d", fv_cyc - c0, 30 + S + 3); end
    tests_run++; if (minutes !== 6'd12) begin tests_failed++; $display("FAIL normal_minutes got %0d want 12", minutes); end
    tests_run++; if (seconds !== 6'd34) begin tests_failed++; $display("FAIL normal_seconds got %0d want 34", seconds); end
    tests_run++; if (digit_blank !== 4'b0000) begin tests_failed++; $display("FAIL normal_blank got %b want 0000", digit_blank); end
    tests_run++; if (div - d0 !== 0) begin tests_failed++; $display("FAIL normal_model got %0d diverging cycles want 0", div - d0); end
  endtask

  task automatic test_glitch();
    int d0;
    d0 = div;
    hold(4'b0111, dp(1), 10); hold(4'b1011, dp(0), 10); hold(4'b1101, dp(2), 10);
    fv_n = 0;
    for (int i = 0; i < 4; i++) begin hold(4'b1110, dp(5), 3); hold(4'b1110, dp(6), 3); end
    hold(4'b1110, dp(5), 3);
    hold(4'hF, 7'h7F, 3);
    tests_run++; if (fv_n !== 0) begin tests_failed++; $display("FAIL glitch_filtered got %0d frames want 0", fv_n); end
    hold(4'b1110, dp(6), 6);
    hold(4'hF, 7'h7F, 3);
    tests_run++; if (fv_n !== 1) begin tests_failed++; $display("FAIL glitch_accept got %0d frames want 1", fv_n); end
    tests_run++; if (minutes !== 6'd10 || seconds !== 6'd26) begin tests_failed++; $display("FAIL glitch_value got %0d:%0d want 10:26", minutes, seconds); end
    tests_run++; if (div - d0 !== 0) begin tests_failed++; $display("FAIL glitch_model got %0d diverging cycles want 0", div - d0); end
  endtask

  task automatic test_blink();
    int d0;
    d0 = div; fv_n = 0;
    hold(4'b0111, dp(5), 10); hold(4'b1011, dp(9), 10);
    hold(4'b1101, dp(0), 10); hold(4'b1110, dp(7), 10);
    hold(4'hF, 7'h7F, 3);
    tests_run++; if (minutes !== 6'd59 || seconds !== 6'd7 || digit_blank !== 4'b0000) begin tests_failed++; $display("FAIL blink_first got %0d:%0d blank %b want 59:7 blank 0000", minutes, seconds, digit_blank); end
    hold(4'b0111, 7'h7F, 10); hold(4'b1011, 7'h7F, 10);
    hold(4'b1101, dp(0), 10); hold(4'b1110, dp(7), 10);
    hold(4'hF, 7'h7F, 3);
    tests_run++; if (fv_n !== 2) begin tests_failed++; $display("FAIL blink_frames got %0d want 2", fv_n); end
    tests_run++; if (minutes !== 6'd59 || seconds !== 6'd7) begin tests_failed++; $display("FAIL blink_hold got %0d:%0d want 59:7", minutes, seconds); end
    tests_run++; if (digit_blank !== 4'b1100) begin tests_failed++; $display("FAIL blink_mask got %b want 1100", digit_blank); end
    tests_run++; if (div - d0 !== 0) begin tests_failed++; $display("FAIL blink_model got %0d diverging cycles want 0", div - d0); end
  endtask

  task automatic test_illegal();
    int d0;
    d0 = div; fv_n = 0; err_n = 0;
    hold(4'b1101, 7'b0110110, 10);
    hold(4'b0111, dp(7), 10);
    hold(4'hF, 7'h7F, 3);
    tests_run++; if (err_n !== 2) begin tests_failed++; $display("FAIL illegal_pulses got %0d want 2", err_n); end
    tests_run++; if (err_count !== 8'd2) begin tests_failed++; $display("FAIL illegal_count got %0d want 2", err_count); end
    tests_run++; if (fv_n !== 0) begin tests_failed++; $display("FAIL illegal_no_frame got %0d want 0", fv_n); end
    tests_run++; if (div - d0 !== 0) begin tests_failed++; $display("FAIL illegal_model got %0d diverging cycles want 0", div - d0); end
  endtask

  task automatic test_stale();
    int c0, c1, d0;
    d0 = div; c0 = cyc; rise_cyc = -1; fall_cyc = -1;
    hold(4'b1110, dp(3), 8);
    hold(4'hF, 7'h7F, 120);
    tests_run++; if (rise_cyc - c0 !== S + 2 + T) begin tests_failed++; $display("FAIL stale_rise got %0d want %0d", rise_cyc - c0, S + 2 + T); end
    tests_run++; if (stale !== 1'b1) begin tests_failed++; $display("FAIL stale_level got %b want 1", stale); end
    c1 = cyc;
    hold(4'b1110, dp(8), 10);
    tests_run++; if (fall_cyc - c1 !== S + 2) begin tests_failed++; $display("FAIL stale_fall got %0d want %0d", fall_cyc - c1, S + 2); end
    tests_run++; if (div - d0 !== 0) begin tests_failed++; $display("FAIL stale_model got %0d diverging cycles want 0", div - d0); end
  endtask

  task automatic test_random();
    int d0, f0, r;
    logic [3:0] an;
    logic [6:0] sg;
    d0 = div; f0 = m_frames; fv_n = 0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 15);
      if (r < 12) an = 4'b1111 ^ (4'b0001 << (r % 4));
      else if (r < 14) an = 4'b1111;
      else an = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) sg = pat[$urandom_range(0, 9)];
      else if (r == 7) sg = 7'b1111111;
      else sg = 7'($urandom);
      hold(an, sg, $urandom_range(2, 9));
    end
    hold(4'hF, 7'h7F, 3);
    tests_run++; if (fv_n !== m_frames - f0) begin tests_failed++; $display("FAIL random_frames got %0d want %0d", fv_n, m_frames - f0); end
    tests_run++; if (err_count !== 8'(m_errcnt)) begin tests_failed++; $display("FAIL random_err_count got %0d want %0d", err_count, m_errcnt); end
    tests_run++; if (minutes !== 6'(m_min) || seconds !== 6'(m_sec)) begin tests_failed++; $display("FAIL random_time got %0d:%0d want %0d:%0d", minutes, seconds, m_min, m_sec); end
    tests_run++; if (div - d0 !== 0) begin tests_failed++; $display("FAIL random_model got %0d diverging cycles want 0", div - d0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    hold(4'b0111, dp(2), 10); hold(4'b1011, dp(3), 10);
    hold(4'b1101, 7'b1111110, 10);
    rst = 1'b0; anode_in = 4'hF; seg_in = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL midreset_err_count got %0d want 0", err_count); end
    model_reset();
    rst = 1'b1;
    d0 = div; fv_n = 0;
    hold(4'hF, 7'h7F, 6);
    hold(4'b1101, dp(4), 10); hold(4'b1110, dp(5), 10);
    hold(4'hF, 7'h7F, 5);
    tests_run++; if (fv_n !== 0) begin tests_failed++; $display("FAIL midreset_discard got %0d frames want 0", fv_n); end
    hold(4'b0111, dp(2), 10); hold(4'b1011, dp(3), 10);
    hold(4'hF, 7'h7F, 3);
    tests_run++; if (fv_n !== 1 || minutes !== 6'd23 || seconds !== 6'd45) begin tests_failed++; $display("FAIL midreset_frame got %0d frames %0d:%0d want 1 frame 23:45", fv_n, minutes, seconds); end
    tests_run++; if (div - d0 !== 0) begin tests_failed++; $display("FAIL midreset_model got %0d diverging cycles want 0", div - d0); end
  endtask

  initial begin
    m_frames = 0;
    model_reset();
    anode_in = 4'hF; seg_in = 7'h7F; rst = 1'b0;
    test_reset();
    test_normal_frame();
    test_glitch();
    test_blink();
    test_illegal();
    test_stale();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
